// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin arbiter sharing one SPI shift engine between requesters
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   req                 per-requester level request, held until done
//   req_wdata           32-bit word per requester, sampled at grant
//   gnt                 one-hot owner, grant cycle through done cycle
//   done                one-cycle completion pulse to the owner
//   rdata, err          read word and timeout flag, updated in the done cycle
//   go_transfer         stretched start pulse to the shift engine
//   data_write_to_spi   owner's word, held from grant to next grant
//   data_pack_ready     engine completion level (rising edge = finished)
//   data_read_from_spi  engine read word
module spi_xfer_arbiter #(
  parameter int N_REQ       = 2,
  parameter int GO_LEN      = 7,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 go_transfer,
  output logic [31:0]          data_write_to_spi,
  input  logic                 data_pack_ready,
  input  logic [31:0]          data_read_from_spi
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GO, S_WAIT, S_DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            found;
  logic            dpr_q;
  logic            dpr_rise;
  logic            edge_flag;
  logic [3:0]      go_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            xfer_ok;
  logic            xfer_tmo;

  assign dpr_rise = data_pack_ready & ~dpr_q;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    xfer_ok    = 1'b0;
    xfer_tmo   = 1'b0;
    case (state)
      S_IDLE: if (gap_cnt == '0 && found) state_next = S_GO;
      S_GO:   if (go_cnt == 4'd0) state_next = S_WAIT;
      S_WAIT: begin
        // An edge caught during GO is remembered in edge_flag; edge beats timeout.
        if (dpr_rise || edge_flag) begin
          xfer_ok    = 1'b1;
          state_next = S_DONE;
        end else if (TIMEOUT_CYC != 0 && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          xfer_tmo   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      ptr               <= PW'(N_REQ - 1);
      dpr_q             <= 1'b0;
      edge_flag         <= 1'b0;
      go_cnt            <= '0;
      gap_cnt           <= '0;
      tmo_cnt           <= '0;
      gnt               <= '0;
      done              <= '0;
      rdata             <= '0;
      err               <= 1'b0;
      go_transfer       <= 1'b0;
      data_write_to_spi <= '0;
    end else begin
      state <= state_next;
      dpr_q <= data_pack_ready;
      done  <= '0;
      case (state)
        S_IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (found) begin
            gnt               <= N_REQ'(1) << win;
            ptr               <= win;
            data_write_to_spi <= req_wdata[32*win +: 32];
            go_transfer       <= 1'b1;
            go_cnt            <= 4'(GO_LEN - 1);
            edge_flag         <= 1'b0;
          end
        end
        S_GO: begin
          if (dpr_rise) edge_flag <= 1'b1;
          if (go_cnt == 4'd0) begin
            go_transfer <= 1'b0;
            tmo_cnt     <= '0;
          end else begin
            go_cnt <= go_cnt - 1'b1;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (xfer_ok) begin
            rdata <= data_read_from_spi;
            err   <= 1'b0;
            done  <= gnt;
          end else if (xfer_tmo) begin
            rdata <= '0;
            err   <= 1'b1;
            done  <= gnt;
          end
        end
        S_DONE: begin
          gnt       <= '0;
          gap_cnt   <= GW'(GAP_CYC);
          edge_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
